// File: rtl/pc_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage_pkg
// Description : Shared types and constants for the PC / instruction-fetch
//               stage: fetch FSM encoding, bubble word, reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_stage_pkg;

  // FETCH: normal fetching. DISCARD: waiting out a fetch whose result is
  // already known to be on the wrong path.
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  // sll $0,$0,0 - the architectural no-op used for bubbles and flushes.
  localparam logic [31:0] C_NOP_WORD = 32'h0000_0000;

  // PC loaded when leaving reset.
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  // Redirect targets must be word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_stage_ifid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_pipe_reg
// Description : 65-bit IF/ID pipeline register {PC+4, instruction, valid}
//               with load, flush and implicit hold.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_pipe_reg
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = C_NOP_WORD
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_plus4_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // Reset and flush both leave a bubble; flush beats load; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      pc_plus4_q <= 32'h0000_0000;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      pc_plus4_q <= pc_plus4_i;
      instr_q    <= instr_i;
      valid_q    <= 1'b1;
    end
  end

  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage
// Description : Program counter, next-PC selection (PC+4 / branch / jump),
//               instruction-memory ready handshake and IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = C_RESET_PC,
  parameter logic [31:0] NOP_INSTR = C_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic [31:0] Instruction,
  output logic [31:0] PCResult,
  output logic [31:0] ImemAddr,
  output logic        ImemReq,
  output logic [31:0] IFID_PCPlus4,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;

  logic         redirect;
  logic [31:0]  target;
  logic         ifid_load;
  logic         ifid_flush;

  // Jump wins over a simultaneous branch; the target is always word aligned.
  assign redirect = Jump | BranchTaken;
  assign target   = align_word(Jump ? JumpTarget : BranchTarget);

  // State, PC and pending-target registers; reset overrides everything.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Next-PC selection, fetch FSM and IF/ID control. A redirect beats a stall
  // because the redirecting instruction is older than the stalled one.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      FETCH: begin
        if (ImemReady) begin
          if (redirect) begin
            pc_d       = target;
            ifid_flush = 1'b1;
          end else if (!Stall) begin
            pc_d      = PCAddResult;
            ifid_load = 1'b1;
          end
        end else begin
          if (redirect) begin
            // The fetch of the old PC is still in flight; remember where to go
            // once it completes instead of changing the address under it.
            pend_d     = target;
            ifid_flush = 1'b1;
            state_d    = DISCARD;
          end else if (!Stall) begin
            ifid_flush = 1'b1;
          end
        end
      end
      DISCARD: begin
        ifid_flush = 1'b1;
        if (redirect) begin
          pend_d = target;
        end
        if (ImemReady) begin
          pc_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  ifid_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk_i      (Clk),
    .rst_n_i    (Reset),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .pc_plus4_i (PCAddResult),
    .instr_i    (Instruction),
    .pc_plus4_o (IFID_PCPlus4),
    .instr_o    (IFID_Instruction),
    .valid_o    (IFID_Valid)
  );

  assign PCResult = pc_q;
  assign ImemAddr = pc_q;
  assign ImemReq  = Reset;

endmodule
`default_nettype wire

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Upstream neighbour of the PC+4 incrementer. Holds the program counter and drives it to the incrementer and to instruction memory.
- Selects the next PC from PC+4, a branch target or a jump target, and handles the instruction-memory ready handshake.
- Loads the IF/ID pipeline register, with stall-hold and flush, that feeds decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on a bubble or flush (sll $0,$0,0).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- PCAddResult  in  32  PC+4 returned by the incrementer for the current PCResult.
- BranchTaken  in  1  branch redirect request from the branch resolution stage.
- BranchTarget  in  32  branch target address.
- Jump  in  1  jump redirect request.
- JumpTarget  in  32  jump target address.
- Stall  in  1  hazard-unit stall: hold PC and IF/ID.
- ImemReady  in  1  instruction memory has valid data for ImemAddr this cycle.
- Instruction  in  32  instruction word from memory, valid when ImemReady=1.
- PCResult  out  32  current PC, feeds the incrementer.
- ImemAddr  out  32  fetch address; always equals PCResult.
- ImemReq  out  1  fetch request; 1 whenever out of reset.
- IFID_PCPlus4  out  32  registered PC+4 of the instruction in IF/ID.
- IFID_Instruction  out  32  registered instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real instruction.

Behaviour:
- Reset (Reset=0 at the edge) applies to every register:
  - PCResult=RESET_PC, state=FETCH, PendTarget=0.
  - IFID_PCPlus4=0, IFID_Instruction=NOP_INSTR, IFID_Valid=0.
  - ImemReq=0 while Reset is low.
  - Reset wins over all other inputs, including mid-wait in DISCARD.
- Redirect = Jump | BranchTaken. The target is JumpTarget if Jump=1, else BranchTarget.
  - Target bits [1:0] are forced to 00 before use.
- Redirect has priority over Stall, because the redirecting instruction is older.
- State FETCH, ImemReady=1:
  - If Redirect: PC<=target and the IF/ID slot is flushed (PCPlus4=0, Instr=NOP_INSTR, Valid=0).
  - Else if Stall: PC and IF/ID hold.
  - Else: PC<=PCAddResult, and IF/ID<={PCAddResult, Instruction, 1}.
- State FETCH, ImemReady=0:
  - If Redirect: PendTarget<=target, PC holds, IF/ID is flushed, next state is DISCARD.
  - Else: PC holds. IF/ID holds if Stall=1, otherwise it is loaded with a bubble.
- State DISCARD: the outstanding fetch of the old PC must complete before the PC changes.
  - ImemAddr stays at the old PC.
  - A new Redirect overwrites PendTarget; the latest redirect wins.
  - IF/ID stays a bubble regardless of Stall.
  - On ImemReady=1: the returned Instruction is discarded and PC<=target, where target is this cycle's redirect target if Redirect=1, else PendTarget. Next state is FETCH.
- Latency: an instruction accepted at edge N appears in IF/ID after edge N, i.e. one cycle.
- The PC wraps modulo 2^32 through the incrementer (FFFF_FFFC -> 0000_0000); no special handling.
- Simultaneous Jump and BranchTaken: Jump wins.

Decomposition:
- Shared package holds:
  - the state encoding (FETCH=1'b0, DISCARD=1'b1);
  - the NOP word;
  - the reset PC constant.
- One natural sub-module: ifid_pipe_reg, a 65-bit register with hold, flush and load controls.
- The PC register, next-PC mux and FSM stay in pc_fetch_stage.

Test Plan:
- Reset and free-run: Reset=0 for 2 cycles, then 1, with ImemReady=1 and the incrementer modelled.
  - PCResult goes 0 -> 4 -> 8 -> C.
  - IFID_PCPlus4 lags by one cycle, with IFID_Valid=1.
- Stall: with PC=0x10, hold Stall=1 for 3 cycles.
  - PCResult stays 0x10.
  - IF/ID keeps {0x10, instr@0xC, 1}.
  - When Stall drops, the PC resumes at 0x14.
- Redirect priority at PC=0x20 with Jump=1 (JumpTarget=0x400), BranchTaken=1 (BranchTarget=0x300), Stall=1.
  - Next PC=0x400.
  - IFID_Valid=0 and IFID_Instruction=0.
- Redirect during a memory wait at PC=0x40 with ImemReady=0.
  - Pulse BranchTaken (target 0x103); state becomes DISCARD and ImemAddr stays 0x40.
  - Two cycles later pulse Jump (0x800), then raise ImemReady.
  - The returned instruction is dropped, the PC becomes 0x800, and no valid IF/ID occurs for it.
- Misaligned target and wrap-around:
  - BranchTarget=0x0000_0107 gives PC=0x104.
  - From PC=FFFF_FFFC, sequential fetch gives PC=0.
- Reset mid-DISCARD: assert Reset=0 while waiting.
  - Next edge: PC=RESET_PC, state FETCH, IFID_Valid=0, and the pending target is cleared.
